// File: rtl/divu_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : divu_seq_unit_if
// Description : Request/result bundle between the EX stage and the
//               sequential unsigned divider (operands in, HI/LO and status out).
// Revision    : 1.0 - initial release
// ============================================================================
interface divu_seq_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [CNT_W-1:0] o_cycles_left;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    // Pipeline side: issues requests, observes status and results
    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_busy, o_done, o_div_by_zero, o_cycles_left, o_hi, o_lo
    );

    // Divider side
    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_busy, o_done, o_div_by_zero, o_cycles_left, o_hi, o_lo
    );
endinterface
`default_nettype wire

// File: rtl/divu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : divu_seq_unit
// Description : Multi-cycle restoring unsigned divider, one quotient bit per
//               clock. Holds HI (remainder) / LO (quotient) for MFHI/MFLO.
//               Divide-by-zero short-circuits to HI=dividend, LO=all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module divu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    divu_seq_unit_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;
    logic             w_div_zero;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;

    // Trial remainder is one bit wider than the operands so the shifted-in
    // value can exceed any divisor without wrapping; the borrow of the
    // subtraction doubles as the "trial >= divisor" decision.
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // One restoring-division step on the current remainder/quotient pair
    always_comb begin
        w_trial    = {r_rem, r_q[WIDTH-1]};
        w_diff     = w_trial - {1'b0, r_dvsr};
        w_ge       = ~w_diff[WIDTH];
        w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_q_next   = {r_q[WIDTH-2:0], w_ge};
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; FIN accepts a new request so back-to-back issue has no gap
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_div_zero   = (bus.i_divisor == '0);
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_accept = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_last       = 1'b1;
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                if (bus.i_start) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_accept) begin
            w_state_next = w_div_zero ? S_FIN : S_RUN;
        end
    end

    // Operand capture, iteration and HI/LO commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_dvsr <= '0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_hi  <= bus.i_dividend;
                r_lo  <= '1;
                r_dbz <= 1'b1;
            end else begin
                r_q    <= bus.i_dividend;
                r_dvsr <= bus.i_divisor;
                r_rem  <= '0;
                r_cnt  <= c_CNT_INIT;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - c_CNT_ONE;
            if (w_last) begin
                r_hi  <= w_rem_next;
                r_lo  <= w_q_next;
                r_dbz <= 1'b0;
            end
        end
    end

    // Status flags registered from the next state so outputs come straight off flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_FIN);
        end
    end

    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_dbz;
    assign bus.o_cycles_left = r_cnt;
    assign bus.o_hi          = r_hi;
    assign bus.o_lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_divu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_divu_seq_unit
// Description : Scoreboard bench for divu_seq_unit. Requests push expected
//               HI/LO/flag (plain / and % arithmetic) into a queue; a monitor
//               pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divu_seq_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dbz;
    } result_t;

    logic    clk;
    logic    rst_n;
    result_t sb[$];
    int      n_checks;
    int      n_pass;

    divu_seq_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    divu_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference model: unsigned quotient/remainder, or the zero-divisor convention
    function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        result_t r;
        if (b == 0) begin
            r.hi  = a;
            r.lo  = {WIDTH{1'b1}};
            r.dbz = 1'b1;
        end else begin
            r.hi  = a % b;
            r.lo  = a / b;
            r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && bus.o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                chk("hi",  64'(bus.o_hi),  64'(e.hi));
                chk("lo",  64'(bus.o_lo),  64'(e.lo));
                chk("dbz", 64'(bus.o_div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Called at a negedge: present a request for one edge and log its expected result
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.i_start    = 1'b1;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Starting at negedge number k0 after the start edge, wait for done;
    // returns latency in cycles, busy cycles seen and cycles_left mismatches
    task automatic measure(input int k0, output int lat, output int busyc, output int badcnt);
        lat = 0; busyc = 0; badcnt = 0;
        for (int k = k0; k <= k0 + 100; k++) begin
            if (bus.o_busy) busyc++;
            if (k <= WIDTH + 1 && bus.o_cycles_left != CNT_W'(WIDTH + 1 - k)) badcnt++;
            if (bus.o_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, busyc, badcnt, extra;
        logic [WIDTH-1:0] a, b;
        n_checks = 0;
        n_pass   = 0;
        bus.i_start    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_cnt",  64'(bus.o_cycles_left), 64'd0);
        chk("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        chk("rst_dbz",  64'(bus.o_div_by_zero), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic division with full timing profile
        issue(32'd100, 32'd7);
        measure(1, lat, busyc, badcnt);
        chk("basic_latency", 64'(lat), 64'd33);
        chk("basic_busy_cycles", 64'(busyc), 64'd32);
        chk("basic_cnt_seq", 64'(badcnt), 64'd0);
        @(negedge clk);
        chk("idle_after_done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);

        // Full-width operands
        issue(32'hFFFF_FFFF, 32'd1);
        measure(1, lat, busyc, badcnt);
        @(negedge clk);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        measure(1, lat, busyc, badcnt);
        @(negedge clk);

        // Divide by zero, then a normal division clears the flag
        issue(32'd12345, 32'd0);
        measure(1, lat, busyc, badcnt);
        chk("dbz_latency", 64'(lat), 64'd1);
        chk("dbz_busy", 64'(busyc), 64'd0);
        @(negedge clk);
        issue(32'd9, 32'd3);
        measure(1, lat, busyc, badcnt);
        @(negedge clk);

        // Start during RUN is ignored
        issue(32'd50, 32'd5);
        repeat (9) @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_dividend = 32'd99;
        bus.i_divisor  = 32'd9;
        @(negedge clk);
        bus.i_start = 1'b0;
        measure(11, lat, busyc, badcnt);
        chk("ignored_latency", 64'(lat), 64'd33);
        chk("ignored_cnt_seq", 64'(badcnt), 64'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) extra++;
        end
        chk("ignored_no_second_done", 64'(extra), 64'd0);

        // Back-to-back: new request presented during the done cycle
        issue(32'd1000, 32'd3);
        measure(1, lat, busyc, badcnt);
        issue(32'd7, 32'd2);
        chk("b2b_busy_reasserts", 64'(bus.o_busy), 64'd1);
        measure(1, lat, busyc, badcnt);
        chk("b2b_latency", 64'(lat), 64'd33);
        @(negedge clk);

        // Asynchronous reset in the middle of a division
        issue(32'd77, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        chk("midrst_done", 64'(bus.o_done), 64'd0);
        chk("midrst_cnt",  64'(bus.o_cycles_left), 64'd0);
        chk("midrst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd77, 32'd7);
        measure(1, lat, busyc, badcnt);
        chk("post_rst_latency", 64'(lat), 64'd33);
        @(negedge clk);

        // Randomized operands, biased toward interesting divisors
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = '0;
                default: b = a + $urandom_range(0, 3);
            endcase
            issue(a, b);
            measure(1, lat, busyc, badcnt);
            chk("rand_latency", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
            @(negedge clk);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
